// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source skid FIFOs for non-stallable functional units,
// round-robin selection of one buffered result per cycle onto a registered CDB.
package cdb_pkg;
  typedef struct packed {
    logic        valid;
    logic [5:0]  rob_tag;
    logic [31:0] data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [63:0] rvfi;
  } cdb_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_SRC      = 3,
  parameter int SKID_DEPTH   = 4,
  parameter int INFLIGHT_MAX = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  cdb_t [NUM_SRC-1:0]     src_in,
  output logic [NUM_SRC-1:0]     src_stall,
  output cdb_t                   cdb_out,
  output logic [NUM_SRC-1:0]     overflow_err
);

  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(SKID_DEPTH);
  localparam logic [CNT_W-1:0] INFLIGHT_C = CNT_W'(INFLIGHT_MAX);
  localparam logic [RR_W-1:0]  LAST_SRC   = RR_W'(NUM_SRC - 1);

  cdb_t             mem_q   [NUM_SRC][SKID_DEPTH];
  cdb_t             mem_d   [NUM_SRC][SKID_DEPTH];
  logic [PTR_W-1:0] head_q  [NUM_SRC];
  logic [PTR_W-1:0] head_d  [NUM_SRC];
  logic [PTR_W-1:0] tail_q  [NUM_SRC];
  logic [PTR_W-1:0] tail_d  [NUM_SRC];
  logic [CNT_W-1:0] count_q [NUM_SRC];
  logic [CNT_W-1:0] count_d [NUM_SRC];
  logic [RR_W-1:0]  rr_q, rr_d;
  cdb_t             cdb_q, cdb_d;
  logic [NUM_SRC-1:0] ovf_q, ovf_d;

  logic [NUM_SRC-1:0] nonempty;
  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] push;
  logic               grant_vld;
  logic [RR_W-1:0]    grant_idx;
  logic [RR_W-1:0]    cand_idx;
  cdb_t               head_sel;

  function automatic logic [RR_W-1:0] rr_next(input logic [RR_W-1:0] k);
    if (k == LAST_SRC) rr_next = '0;
    else               rr_next = k + RR_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      nonempty[i]  = (count_q[i] != '0);
      full[i]      = (count_q[i] == DEPTH_C);
      // Stop issue while the free slots could not absorb the results still in flight.
      src_stall[i] = ((DEPTH_C - count_q[i]) <= INFLIGHT_C);
    end
  end

  // Round-robin search starting at rr_q over the registered (pre-edge) occupancy.
  always_comb begin
    int cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int off = 0; off < NUM_SRC; off++) begin
      cand = int'(rr_q) + off;
      if (cand >= NUM_SRC) cand = cand - NUM_SRC;
      cand_idx = RR_W'(cand);
      if (!grant_vld && nonempty[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    head_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i] = grant_vld && (grant_idx == RR_W'(i));
      if (pop[i]) head_sel = mem_q[i][head_q[i]];
      // A full FIFO still accepts when its head leaves on the same edge.
      push[i] = src_in[i].valid && (!full[i] || pop[i]);
    end
  end

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rr_d    = rr_q;
    ovf_d   = ovf_q;
    cdb_d   = '0;
    if (flush) begin
      // Flush wins over everything: drop buffered and incoming results, keep rr and errors.
      for (int i = 0; i < NUM_SRC; i++) begin
        head_d[i]  = '0;
        tail_d[i]  = '0;
        count_d[i] = '0;
      end
    end else begin
      if (grant_vld) begin
        cdb_d = head_sel;
        rr_d  = rr_next(grant_idx);
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_in[i].valid && !push[i]) ovf_d[i] = 1'b1;
        if (push[i]) begin
          mem_d[i][tail_q[i]] = src_in[i];
          tail_d[i]           = tail_q[i] + PTR_W'(1);
        end
        if (pop[i]) head_d[i] = head_q[i] + PTR_W'(1);
        count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Storage carries no reset: validity is tracked entirely by the pointers and counts.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        head_q[i]  <= '0;
        tail_q[i]  <= '0;
        count_q[i] <= '0;
      end
      rr_q  <= '0;
      cdb_q <= '0;
      ovf_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rr_q    <= rr_d;
      cdb_q   <= cdb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign cdb_out      = cdb_q;
  assign overflow_err = ovf_q;

endmodule
